// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer: state encoding,
// digit limits and the BCD-to-7-segment decoder used by the board displays.
package countdown_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADED = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [3:0] DIGIT_MAX_9 = 4'd9;
  localparam logic [3:0] DIGIT_MAX_5 = 4'd5;

  // Active-low segments, bit0 = a .. bit6 = g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] val, input logic [3:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit with synchronous load; wraps 0 -> MAX when
// decremented, so a chain of these forms the MM:SS borrow chain.
module bcd_down_digit
  import countdown_timer_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX_9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] val,
  output logic       is_zero
);

  logic [3:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = load_val;
    end else if (dec) begin
      val_d = (val_q == 4'd0) ? MAX : (val_q - 4'd1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q <= 4'd0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val     = val_q;
  assign is_zero = (val_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer: synchronised start/stop and load buttons, run-gated
// tick divider, BCD borrow chain and registered 7-segment / status outputs.
//
// state  | meaning
// IDLE   | after reset, or a 00:00 preset was loaded; start ignored
// LOADED | preset held in the digits, waiting for start
// RUN    | divider counting, digits decrement on each tick
// PAUSE  | digits and divider frozen, start resumes
// DONE   | reached 00:00, alarm flag high until the next load
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start_Stop,
  input  logic        load,
  input  logic [15:0] preset,
  output logic [6:0]  Out1,
  output logic [6:0]  Out2,
  output logic [6:0]  Out3,
  output logic [6:0]  Out4,
  output logic        done,
  output logic        running
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(TICK_DIV - 1);

  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] ld_sync_q, ld_sync_d;
  logic                   ss_prev_q, ss_prev_d;
  logic                   ld_prev_q, ld_prev_d;
  logic                   ss_edge, ld_edge;

  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   tick, dig_load, dec_en;

  logic [3:0]             pre_so, pre_st, pre_mo, pre_mt;
  logic                   preset_zero;
  logic [3:0]             so_val, st_val, mo_val, mt_val;
  logic                   so_zero, st_zero, mo_zero, mt_zero;
  logic                   all_zero, last_second;

  logic [6:0]             seg1_q, seg1_d, seg2_q, seg2_d, seg3_q, seg3_d, seg4_q, seg4_d;
  logic                   done_q, done_d, running_q, running_d;

  // Button synchronisers followed by a single-cycle rising-edge detect
  always_comb begin
    ss_sync_d[0] = Start_Stop;
    ld_sync_d[0] = load;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      ss_sync_d[i] = ss_sync_q[i-1];
      ld_sync_d[i] = ld_sync_q[i-1];
    end
    ss_prev_d = ss_sync_q[SYNC_STAGES-1];
    ld_prev_d = ld_sync_q[SYNC_STAGES-1];
  end

  assign ss_edge = ss_sync_q[SYNC_STAGES-1] & ~ss_prev_q;
  assign ld_edge = ld_sync_q[SYNC_STAGES-1] & ~ld_prev_q;

  assign pre_so      = clamp_digit(preset[3:0],   DIGIT_MAX_9);
  assign pre_st      = clamp_digit(preset[7:4],   DIGIT_MAX_5);
  assign pre_mo      = clamp_digit(preset[11:8],  DIGIT_MAX_9);
  assign pre_mt      = clamp_digit(preset[15:12], DIGIT_MAX_9);
  assign preset_zero = (preset == 16'h0000);

  assign all_zero    = mt_zero & mo_zero & st_zero & so_zero;
  assign last_second = mt_zero & mo_zero & st_zero & (so_val == 4'd1);

  // A zero preset always lands in IDLE so RUN never starts from 00:00
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    tick     = 1'b0;
    dig_load = 1'b0;
    if (ld_edge) begin
      dig_load = 1'b1;
      div_d    = '0;
      state_d  = preset_zero ? ST_IDLE : ST_LOADED;
    end else begin
      unique case (state_q)
        ST_LOADED: begin
          if (ss_edge) begin
            state_d = ST_RUN;
            div_d   = '0;
          end
        end
        ST_RUN: begin
          if (ss_edge) begin
            state_d = ST_PAUSE;
          end else if (div_q == DIV_TC) begin
            div_d = '0;
            tick  = 1'b1;
            if (all_zero || last_second) begin
              state_d = ST_DONE;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          if (ss_edge) begin
            state_d = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  assign dec_en = tick & ~all_zero;

  bcd_down_digit #(.MAX(DIGIT_MAX_9)) u_sec_ones (
    .clk      (clk),
    .rst      (rst),
    .load     (dig_load),
    .load_val (pre_so),
    .dec      (dec_en),
    .val      (so_val),
    .is_zero  (so_zero)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX_5)) u_sec_tens (
    .clk      (clk),
    .rst      (rst),
    .load     (dig_load),
    .load_val (pre_st),
    .dec      (dec_en & so_zero),
    .val      (st_val),
    .is_zero  (st_zero)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX_9)) u_min_ones (
    .clk      (clk),
    .rst      (rst),
    .load     (dig_load),
    .load_val (pre_mo),
    .dec      (dec_en & so_zero & st_zero),
    .val      (mo_val),
    .is_zero  (mo_zero)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX_9)) u_min_tens (
    .clk      (clk),
    .rst      (rst),
    .load     (dig_load),
    .load_val (pre_mt),
    .dec      (dec_en & so_zero & st_zero & mo_zero),
    .val      (mt_val),
    .is_zero  (mt_zero)
  );

  always_comb begin
    seg1_d    = bcd_to_seg(so_val);
    seg2_d    = bcd_to_seg(st_val);
    seg3_d    = bcd_to_seg(mo_val);
    seg4_d    = bcd_to_seg(mt_val);
    done_d    = (state_d == ST_DONE);
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sync_q <= '0;
      ld_sync_q <= '0;
      ss_prev_q <= 1'b0;
      ld_prev_q <= 1'b0;
      state_q   <= ST_IDLE;
      div_q     <= '0;
      seg1_q    <= SEG_0;
      seg2_q    <= SEG_0;
      seg3_q    <= SEG_0;
      seg4_q    <= SEG_0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      ss_sync_q <= ss_sync_d;
      ld_sync_q <= ld_sync_d;
      ss_prev_q <= ss_prev_d;
      ld_prev_q <= ld_prev_d;
      state_q   <= state_d;
      div_q     <= div_d;
      seg1_q    <= seg1_d;
      seg2_q    <= seg2_d;
      seg3_q    <= seg3_d;
      seg4_q    <= seg4_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign Out1    = seg1_q;
  assign Out2    = seg2_q;
  assign Out3    = seg3_q;
  assign Out4    = seg4_q;
  assign done    = done_q;
  assign running = running_q;

endmodule
